// File: rtl/rf_pkg.sv
// Shared types for the multi-port register file.
package rf_pkg;

    // Clear sweep runs after reset; READY is normal operation.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for hazard detection.
// Ports:
//   clk, rst_n                 clock, async active-low reset (all bits cleared)
//   set_en/set_addr            mark a register pending (wins over a clear)
//   clr_en0/1, clr_addr0/1     clear pending bits (writeback completions)
//   addr_a/b -> lookup_a/b_c   combinational busy lookups
// Callers are expected to pre-qualify enables (range, R0, init state).
module rf_scoreboard #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en0,
    input  logic [ADDR_W-1:0] clr_addr0,
    input  logic              clr_en1,
    input  logic [ADDR_W-1:0] clr_addr1,
    input  logic [ADDR_W-1:0] addr_a,
    output logic              lookup_a_c,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              lookup_b_c
);

    logic [NREGS-1:0] busy;

    // A set in the same cycle as a clear means a new producer was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (set_en && set_addr == ADDR_W'(i)) begin
                    busy[i] <= 1'b1;
                end else if ((clr_en0 && clr_addr0 == ADDR_W'(i)) ||
                             (clr_en1 && clr_addr1 == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Out-of-range addresses match no entry and read as not busy.
    always_comb begin
        lookup_a_c = 1'b0;
        lookup_b_c = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (addr_a == ADDR_W'(i)) lookup_a_c = busy[i];
            if (addr_b == ADDR_W'(i)) lookup_b_c = busy[i];
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: 2 combinational reads, 2 synchronous writes
// (port 1 has priority), optional write->read bypass, optional zero R0,
// busy scoreboard, and a post-reset clear sweep over the array.
// Ports:
//   clk, reset (async, active-low), init_done (sweep finished)
//   rd_addr_a/b -> rd_data_a/b, busy_a/b (combinational)
//   wr_en0/1, wr_addr0/1, wr_data0/1 (writeback)
//   busy_set_en, busy_set_addr (decode issue)
module register_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_done,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_b,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              busy_set_en,
    input  logic [ADDR_W-1:0] busy_set_addr
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    rf_state_e         state;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] regs [NREGS];
    logic              ready;
    logic              wr_ok0, wr_ok1, set_ok;
    logic              hit0_a, hit1_a, hit0_b, hit1_b;
    logic              sb_busy_a, sb_busy_b;

    // Implemented, writable/readable register (R0 excluded when hard-wired).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < NREGS) && !((ZERO_R0 != 0) && (addr == '0));
    endfunction

    // Clear sweep: one register per cycle, then READY until next reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (clr_idx == ADDR_W'(NREGS - 1)) state <= RF_READY;
                    else                               clr_idx <= clr_idx + ADDR_W'(1);
                end
                RF_READY: state <= RF_READY;
                default:  state <= RF_CLEAR;
            endcase
        end
    end

    assign ready     = (state == RF_READY);
    assign init_done = ready;

    assign wr_ok0 = ready && wr_en0 && addr_ok(wr_addr0);
    assign wr_ok1 = ready && wr_en1 && addr_ok(wr_addr1);
    assign set_ok = ready && busy_set_en && addr_ok(busy_set_addr);

    // Array has no reset; the sweep defines it. Port 1 assigned last so it wins.
    always_ff @(posedge clk) begin
        if (state == RF_CLEAR) begin
            regs[IDX_W'(clr_idx)] <= '0;
        end else begin
            if (wr_ok0) regs[IDX_W'(wr_addr0)] <= wr_data0;
            if (wr_ok1) regs[IDX_W'(wr_addr1)] <= wr_data1;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (reset),
        .set_en     (set_ok),
        .set_addr   (busy_set_addr),
        .clr_en0    (wr_ok0),
        .clr_addr0  (wr_addr0),
        .clr_en1    (wr_ok1),
        .clr_addr1  (wr_addr1),
        .addr_a     (rd_addr_a),
        .lookup_a_c (sb_busy_a),
        .addr_b     (rd_addr_b),
        .lookup_b_c (sb_busy_b)
    );

    assign hit0_a = (BYPASS != 0) && wr_en0 && (wr_addr0 == rd_addr_a);
    assign hit1_a = (BYPASS != 0) && wr_en1 && (wr_addr1 == rd_addr_a);
    assign hit0_b = (BYPASS != 0) && wr_en0 && (wr_addr0 == rd_addr_b);
    assign hit1_b = (BYPASS != 0) && wr_en1 && (wr_addr1 == rd_addr_b);

    // Read muxes: invalid address forces 0 ahead of any bypass.
    always_comb begin
        rd_data_a = '0;
        busy_a    = 1'b0;
        if (ready && addr_ok(rd_addr_a)) begin
            if (hit1_a)      rd_data_a = wr_data1;
            else if (hit0_a) rd_data_a = wr_data0;
            else             rd_data_a = regs[IDX_W'(rd_addr_a)];
            busy_a = sb_busy_a && !(hit0_a || hit1_a);
        end
    end

    always_comb begin
        rd_data_b = '0;
        busy_b    = 1'b0;
        if (ready && addr_ok(rd_addr_b)) begin
            if (hit1_b)      rd_data_b = wr_data1;
            else if (hit0_b) rd_data_b = wr_data0;
            else             rd_data_b = regs[IDX_W'(rd_addr_b)];
            busy_b = sb_busy_b && !(hit0_b || hit1_b);
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: three configurations share one stimulus stream
//   0: NREGS=32 BYPASS=1 ZERO_R0=1
//   1: NREGS=32 BYPASS=0 ZERO_R0=0
//   2: NREGS=24 BYPASS=1 ZERO_R0=1
// A behavioural model of each is compared on every negedge; directed
// literal expectations pin the model.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr0, wr_addr1, busy_set_addr;
    logic [31:0] wr_data0, wr_data1;
    logic        wr_en0, wr_en1, busy_set_en;

    logic [31:0] rd_a [3];
    logic [31:0] rd_b [3];
    logic        ba [3];
    logic        bb [3];
    logic        done [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .BYPASS(1), .ZERO_R0(1)) dut0 (
        .clk(clk), .reset(reset), .init_done(done[0]),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_a[0]), .busy_a(ba[0]),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_b[0]), .busy_b(bb[0]),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr));

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .BYPASS(0), .ZERO_R0(0)) dut1 (
        .clk(clk), .reset(reset), .init_done(done[1]),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_a[1]), .busy_a(ba[1]),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_b[1]), .busy_b(bb[1]),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr));

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NREGS(24), .BYPASS(1), .ZERO_R0(1)) dut2 (
        .clk(clk), .reset(reset), .init_done(done[2]),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_a[2]), .busy_a(ba[2]),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_b[2]), .busy_b(bb[2]),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr));

    // ---------------- behavioural model ----------------
    function automatic int nr(input int i);
        return (i == 2) ? 24 : 32;
    endfunction
    function automatic bit byp(input int i);
        return (i != 1);
    endfunction
    function automatic bit zr(input int i);
        return (i != 1);
    endfunction

    logic [31:0] mem  [3][32];
    bit          mbsy [3][32];
    int          cnt = 0;   // posedges since reset release

    function automatic bit okm(input int i, input logic [4:0] a);
        return (int'(a) < nr(i)) && !(zr(i) && a == 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
        if (!reset || cnt < nr(i) || !okm(i, a)) return 32'd0;
        if (byp(i) && wr_en1 && wr_addr1 == a) return wr_data1;
        if (byp(i) && wr_en0 && wr_addr0 == a) return wr_data0;
        return mem[i][a];
    endfunction

    function automatic logic exp_busy(input int i, input logic [4:0] a);
        if (!reset || cnt < nr(i) || !okm(i, a)) return 1'b0;
        if (byp(i) && ((wr_en1 && wr_addr1 == a) || (wr_en0 && wr_addr0 == a))) return 1'b0;
        return mbsy[i][a];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                cnt = 0;
                for (int i = 0; i < 3; i++)
                    for (int r = 0; r < 32; r++) mbsy[i][r] = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (cnt < nr(i)) begin
                        mem[i][cnt] = 32'd0;
                    end else begin
                        if (wr_en0 && okm(i, wr_addr0)) begin
                            mem[i][wr_addr0]  = wr_data0;
                            mbsy[i][wr_addr0] = 1'b0;
                        end
                        if (wr_en1 && okm(i, wr_addr1)) begin
                            mem[i][wr_addr1]  = wr_data1;
                            mbsy[i][wr_addr1] = 1'b0;
                        end
                        if (busy_set_en && okm(i, busy_set_addr)) mbsy[i][busy_set_addr] = 1'b1;
                    end
                end
                if (cnt < 1000) cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("init_done[%0d]", i), 32'(done[i]), 32'(reset && cnt >= nr(i)));
                check($sformatf("rd_data_a[%0d]", i), rd_a[i], exp_rd(i, rd_addr_a));
                check($sformatf("rd_data_b[%0d]", i), rd_b[i], exp_rd(i, rd_addr_b));
                check($sformatf("busy_a[%0d]", i), 32'(ba[i]), 32'(exp_busy(i, rd_addr_a)));
                check($sformatf("busy_b[%0d]", i), 32'(bb[i]), 32'(exp_busy(i, rd_addr_b)));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
        busy_set_en = 1'b0; busy_set_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts posedges from now until each init_done rises (bounded).
    task automatic measure_init(input int hold_wr, output int t0, output int t2);
        t0 = -1; t2 = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == hold_wr) idle();
            if (t0 < 0 && done[0]) t0 = c;
            if (t2 < 0 && done[2]) t2 = c;
            if (t0 >= 0 && t2 >= 0) break;
        end
    endtask

    initial begin
        int t0, t2;
        reset = 1'b0;
        idle();
        rd_addr_a = '0;
        rd_addr_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_init_done", 32'(done[0]), 32'd0);
        reset = 1'b1;

        // 1. sweep length and cleared contents
        measure_init(0, t0, t2);
        check("init_cycles_32", 32'(t0), 32'd32);
        check("init_cycles_24", 32'(t2), 32'd24);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            check("cleared_a", rd_a[0], 32'd0);
            check("cleared_b", rd_b[1], 32'd0);
            tick();
        end

        // 2. bypass vs. no bypass
        wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'h4020_0000; rd_addr_a = 5'd5;
        #1;
        check("bypass_same_cycle", rd_a[0], 32'h4020_0000);
        check("nobypass_old", rd_a[1], 32'd0);
        tick(); idle(); #1;
        check("nobypass_next", rd_a[1], 32'h4020_0000);

        // 3. write-port priority and hard-wired R0
        wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h11;
        wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h22; rd_addr_a = 5'd7;
        #1;
        check("bypass_port1_prio", rd_a[0], 32'h22);
        tick(); idle(); #1;
        check("port1_wins_0", rd_a[0], 32'h22);
        check("port1_wins_1", rd_a[1], 32'h22);
        wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFF; rd_addr_a = 5'd0;
        #1;
        check("r0_bypass_zero", rd_a[0], 32'd0);
        tick(); idle(); #1;
        check("r0_zero", rd_a[0], 32'd0);
        check("r0_plain_reg", rd_a[1], 32'hFFFF);

        // 4. scoreboard
        busy_set_en = 1'b1; busy_set_addr = 5'd9; rd_addr_a = 5'd9;
        #1;
        check("busy_before_set", 32'(ba[0]), 32'd0);
        tick(); idle(); #1;
        check("busy_set_0", 32'(ba[0]), 32'd1);
        check("busy_set_1", 32'(ba[1]), 32'd1);
        wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h99;
        #1;
        check("busy_bypass_forced", 32'(ba[0]), 32'd0);
        check("busy_nobypass_held", 32'(ba[1]), 32'd1);
        tick(); idle(); #1;
        check("busy_cleared", 32'(ba[1]), 32'd0);
        busy_set_en = 1'b1; busy_set_addr = 5'd9;
        wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h9A;
        tick(); idle(); #1;
        check("busy_set_wins", 32'(ba[0]), 32'd1);
        check("set_wins_data", rd_a[0], 32'h9A);

        // 6. out-of-range address on the 24-register instance
        wr_en1 = 1'b1; wr_addr1 = 5'd30; wr_data1 = 32'hDEAD;
        busy_set_en = 1'b1; busy_set_addr = 5'd30; rd_addr_a = 5'd30;
        #1;
        check("oor_bypass_zero", rd_a[2], 32'd0);
        check("inrange_bypass", rd_a[0], 32'hDEAD);
        tick(); idle(); #1;
        check("oor_read_zero", rd_a[2], 32'd0);
        check("oor_not_busy", 32'(ba[2]), 32'd0);
        check("inrange_busy", 32'(ba[0]), 32'd1);

        // Mixed traffic with collisions; the model checks every cycle.
        for (int k = 0; k < 48; k++) begin
            wr_en0 = (k % 3) != 0;  wr_addr0 = 5'((k * 7) % 32);
            wr_data0 = 32'(k) * 32'h0101_0101 ^ 32'hA5;
            wr_en1 = (k % 4) == 1;  wr_addr1 = 5'((k * 5 + 3) % 32);
            wr_data1 = 32'(k) * 32'h0003_0007 + 32'h1000;
            busy_set_en = (k % 2) == 0; busy_set_addr = 5'((k * 11) % 32);
            rd_addr_a = 5'((k * 7) % 32);
            rd_addr_b = 5'((k * 11 + 22) % 32);
            tick();
        end
        idle();

        // 5. reset mid-sweep; writes during the sweep are lost
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (12) tick();
        check("mid_sweep_not_done", 32'(done[0]), 32'd0);
        reset = 1'b0;
        #1;
        check("reset_again_not_done", 32'(done[0]), 32'd0);
        tick();
        reset = 1'b1;
        wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'h1234;
        busy_set_en = 1'b1; busy_set_addr = 5'd4;
        rd_addr_a = 5'd3; rd_addr_b = 5'd4;
        measure_init(10, t0, t2);
        check("restart_cycles_32", 32'(t0), 32'd32);
        check("restart_cycles_24", 32'(t2), 32'd24);
        #1;
        check("clear_write_lost", rd_a[0], 32'd0);
        check("clear_busy_lost", 32'(bb[0]), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
